// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin two-master AXI write-address arbiter with W-beat ordering queue
module axi_wr_arbiter #(
    parameter int AW_W      = 49,
    parameter int W_W       = 37,
    parameter int ORD_DEPTH = 4
) (
    input  logic            AXI_CLK_i,
    input  logic            AXI_RST_i,
    input  logic            M0_AW_VALID,
    input  logic            M1_AW_VALID,
    input  logic [AW_W-1:0] M0_AW_DATA,
    input  logic [AW_W-1:0] M1_AW_DATA,
    input  logic            M0_W_VALID,
    input  logic            M1_W_VALID,
    input  logic [W_W-1:0]  M0_W_DATA,
    input  logic [W_W-1:0]  M1_W_DATA,
    input  logic            aw_out_ready,
    input  logic            w_out_ready,
    output logic            M0_AW_GRANT,
    output logic            M1_AW_GRANT,
    output logic [AW_W-1:0] aw_out,
    output logic            aw_out_valid,
    output logic            aw_sel,
    output logic            M0_W_GRANT,
    output logic            M1_W_GRANT,
    output logic [W_W-1:0]  w_out,
    output logic            w_out_valid,
    output logic            w_sel,
    output logic            ord_full,
    output logic            ord_empty
);
    localparam int PW = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
    typedef enum logic {IDLE, HOLD} state_e;
    state_e               state_q;
    logic                 last_q;
    logic [ORD_DEPTH-1:0] ord_q;
    logic [PW-1:0]        wp_q, rp_q;
    logic [PW:0]          cnt_q;
    logic                 aw_win, aw_take, w_take, w_pop;
    assign ord_full  = cnt_q == (PW+1)'(ORD_DEPTH);
    assign ord_empty = cnt_q == '0;
    assign aw_win  = (M0_AW_VALID & M1_AW_VALID) ? ~last_q : M1_AW_VALID;
    assign aw_take = ~AXI_RST_i & (state_q == IDLE) & (M0_AW_VALID | M1_AW_VALID) & ~ord_full;
    assign M0_AW_GRANT = aw_take & ~aw_win;
    assign M1_AW_GRANT = aw_take & aw_win;
    assign w_sel       = ord_q[rp_q];
    assign w_out       = w_sel ? M1_W_DATA : M0_W_DATA;
    assign w_out_valid = ~ord_empty & (w_sel ? M1_W_VALID : M0_W_VALID);
    assign w_take      = w_out_valid & w_out_ready;
    assign M0_W_GRANT  = w_take & ~w_sel;
    assign M1_W_GRANT  = w_take & w_sel;
    assign w_pop       = w_take & w_out[0];
    // AW FSM: capture the winner in IDLE, hold the payload until downstream accepts it
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            aw_out       <= '0;
            aw_sel       <= 1'b0;
            aw_out_valid <= 1'b0;
        end else if (state_q == IDLE) begin
            if (aw_take) begin
                state_q      <= HOLD;
                last_q       <= aw_win;
                aw_sel       <= aw_win;
                aw_out       <= aw_win ? M1_AW_DATA : M0_AW_DATA;
                aw_out_valid <= 1'b1;
            end
        end else if (aw_out_ready) begin
            state_q      <= IDLE;
            aw_out_valid <= 1'b0;
        end
    end
    // Order queue: master ID pushed at AW grant, popped by the granted LAST beat
    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            ord_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (aw_take) begin
                ord_q[wp_q] <= aw_win;
                wp_q        <= wp_q + 1'b1;
            end
            if (w_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(aw_take) - (PW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: randomized check of axi_wr_arbiter against a queue-based reference model
module tb_axi_wr_arbiter;
    localparam int AW_W = 49, W_W = 37, DEPTH = 4;
    logic            clk = 1'b0, rst = 1'b1;
    logic            m0_awv, m1_awv, m0_wv, m1_wv, aw_rdy, w_rdy;
    logic [AW_W-1:0] m0_awd, m1_awd, aw_out;
    logic [W_W-1:0]  m0_wd, m1_wd, w_out;
    logic            m0_awg, m1_awg, aw_out_valid, aw_sel, m0_wg, m1_wg, w_out_valid, w_sel, ord_full, ord_empty;
    int checks = 0, failures = 0;
    bit              hold, last, exp_sel;
    logic [AW_W-1:0] exp_aw;
    bit              q[$];

    axi_wr_arbiter #(.AW_W(AW_W), .W_W(W_W), .ORD_DEPTH(DEPTH)) dut (
        .AXI_CLK_i(clk), .AXI_RST_i(rst),
        .M0_AW_VALID(m0_awv), .M1_AW_VALID(m1_awv), .M0_AW_DATA(m0_awd), .M1_AW_DATA(m1_awd),
        .M0_W_VALID(m0_wv), .M1_W_VALID(m1_wv), .M0_W_DATA(m0_wd), .M1_W_DATA(m1_wd),
        .aw_out_ready(aw_rdy), .w_out_ready(w_rdy),
        .M0_AW_GRANT(m0_awg), .M1_AW_GRANT(m1_awg), .aw_out(aw_out), .aw_out_valid(aw_out_valid),
        .aw_sel(aw_sel), .M0_W_GRANT(m0_wg), .M1_W_GRANT(m1_wg), .w_out(w_out),
        .w_out_valid(w_out_valid), .w_sel(w_sel), .ord_full(ord_full), .ord_empty(ord_empty));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hold = 0; last = 1; exp_sel = 0; exp_aw = '0; q = {};
    endtask

    task automatic check_reset_state();
        chk("rst_awv", aw_out_valid, 0); chk("rst_aw", aw_out, 0); chk("rst_sel", aw_sel, 0);
        chk("rst_awg", {m0_awg, m1_awg}, 0); chk("rst_wg", {m0_wg, m1_wg}, 0);
        chk("rst_empty", ord_empty, 1); chk("rst_full", ord_full, 0);
    endtask

    // one cycle: drive inputs, check combinational outputs, advance the model, clock, check registers
    task automatic cycle(input int awp, input int lastp);
        bit aw_g, win, wv, w_g, head;
        m0_awv = ($urandom_range(99) < awp); m1_awv = ($urandom_range(99) < awp);
        m0_awd = {$urandom, $urandom}; m1_awd = {$urandom, $urandom};
        m0_wv = $urandom_range(1); m1_wv = $urandom_range(1);
        m0_wd = {$urandom, $urandom}; m1_wd = {$urandom, $urandom};
        m0_wd[0] = ($urandom_range(99) < lastp); m1_wd[0] = ($urandom_range(99) < lastp);
        aw_rdy = ($urandom_range(99) < 70); w_rdy = ($urandom_range(99) < 80);
        #1;
        aw_g = !hold && (m0_awv || m1_awv) && q.size() < DEPTH;
        win  = (m0_awv && m1_awv) ? !last : m1_awv;
        head = q.size() > 0 ? q[0] : 1'b0;
        wv   = q.size() > 0 && (head ? m1_wv : m0_wv);
        w_g  = wv && w_rdy;
        chk("m0_awg", m0_awg, aw_g && !win);
        chk("m1_awg", m1_awg, aw_g && win);
        chk("w_valid", w_out_valid, wv);
        chk("m0_wg", m0_wg, w_g && !head);
        chk("m1_wg", m1_wg, w_g && head);
        if (q.size() > 0) begin
            chk("w_sel", w_sel, head);
            chk("w_out", w_out, head ? m1_wd : m0_wd);
        end
        if (w_g && (head ? m1_wd[0] : m0_wd[0])) void'(q.pop_front());
        if (aw_g) begin
            q.push_back(win); hold = 1; last = win; exp_sel = win;
            exp_aw = win ? m1_awd : m0_awd;
        end else if (hold && aw_rdy) hold = 0;
        @(posedge clk); #1;
        chk("aw_valid", aw_out_valid, hold);
        if (hold) begin
            chk("aw_out", aw_out, exp_aw);
            chk("aw_sel", aw_sel, exp_sel);
        end
        chk("full", ord_full, q.size() == DEPTH);
        chk("empty", ord_empty, q.size() == 0);
    endtask

    initial begin
        {m0_awv, m1_awv, m0_wv, m1_wv, aw_rdy, w_rdy} = '0;
        m0_awd = '0; m1_awd = '0; m0_wd = '0; m1_wd = '0;
        model_reset();
        #1 check_reset_state();
        @(posedge clk); #2 rst = 0;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 400; i++) cycle(r == 1 ? 95 : 60, r == 2 ? 10 : 50);
            m0_awv = 1; m1_awv = 1; m0_wv = 1; m1_wv = 1; w_rdy = 1;
            #1 rst = 1;
            #1 check_reset_state();
            model_reset();
            @(posedge clk); #1 check_reset_state();
            rst = 0;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
